// File: rtl/axis_ad9226_pkg.sv
// Shared types and default sizing for the ADC trigger-capture path.
package axis_ad9226_pkg;

  localparam int DEFAULT_DEPTH     = 1024;
  localparam int DEFAULT_CNT_WIDTH = 16;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PREFILL   = 3'd1,
    ST_WAIT_TRIG = 3'd2,
    ST_POST      = 3'd3,
    ST_READ      = 3'd4
  } cap_state_t;

endpackage

// File: rtl/capture_ram.sv
// Simple dual-port capture buffer: one write port, one registered read port
// whose output holds while rd_en is low. Contents are never reset.
module capture_ram
  import axis_ad9226_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = DEFAULT_DEPTH
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0]    wr_data,
  input  logic                     rd_en,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0]    rd_data
);

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];
  logic [DATA_WIDTH-1:0] rd_data_r;

  // Write port
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  // Registered read port; holding it lets the stream pipeline stall
  always_ff @(posedge clk) begin
    if (rd_en) begin
      rd_data_r <= mem_r[rd_addr];
    end
  end

  assign rd_data = rd_data_r;

endmodule

// File: rtl/axis_trigger_capture.sv
// Armed pre/post-trigger capture into a circular buffer, replayed over AXI-Stream.
// Define AUTO_TRIGGER_EN to add the auto_timeout forced-trigger feature.
module axis_trigger_capture
  import axis_ad9226_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = DEFAULT_DEPTH,
  parameter int CNT_WIDTH  = DEFAULT_CNT_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_data_valid,
  input  logic [DATA_WIDTH-1:0]    in_data,
  input  logic                     trigger,
  input  logic                     arm,
  input  logic [$clog2(DEPTH)-1:0] pre_count,
  input  logic [CNT_WIDTH-1:0]     post_count,
`ifdef AUTO_TRIGGER_EN
  input  logic [CNT_WIDTH-1:0]     auto_timeout,
  output logic                     auto_triggered,
`endif
  output logic [DATA_WIDTH-1:0]    m_axis_tdata,
  output logic                     m_axis_tvalid,
  output logic                     m_axis_tlast,
  input  logic                     m_axis_tready,
  output logic                     busy,
  output logic                     done
);

  localparam int AW = $clog2(DEPTH);
  // Wide enough to hold DEPTH and any post_count without overflow
  localparam int SW = ((CNT_WIDTH > AW) ? CNT_WIDTH : AW) + 1;

  cap_state_t            state_r;
  logic [AW-1:0]         wr_ptr_r, rd_ptr_r, trig_ptr_r, pre_r, pre_cnt_r;
  logic [SW-1:0]         post_r, post_cnt_r, total_r, issue_cnt_r;
  logic                  trig_prev_r, a_valid_r, a_last_r;
  logic [DATA_WIDTH-1:0] tdata_r;
  logic                  tvalid_r, tlast_r, busy_r, done_r;

  logic [SW-1:0]         post_ext_s, room_s, post_clamp_s, total_s;
  logic                  edge_s, forced_s, trig_fire_s, we_s;
  logic                  out_load_s, a_load_s, rd_en_s;
  logic [DATA_WIDTH-1:0] rd_data_s;

`ifdef AUTO_TRIGGER_EN
  logic [CNT_WIDTH-1:0]  auto_to_r, auto_cnt_r;
  logic                  auto_trig_r;
`endif

  // Argument clamping, trigger qualification and read-pipeline enables
  always_comb begin
    post_ext_s = SW'(post_count);
    room_s     = SW'(DEPTH) - SW'(pre_count);
    if (post_count == CNT_WIDTH'(0)) begin
      post_clamp_s = SW'(1);
    end else if (post_ext_s > room_s) begin
      post_clamp_s = room_s;
    end else begin
      post_clamp_s = post_ext_s;
    end
    total_s = SW'(pre_count) + post_clamp_s;

    edge_s   = trigger & ~trig_prev_r;
    forced_s = 1'b0;
`ifdef AUTO_TRIGGER_EN
    if ((auto_to_r != CNT_WIDTH'(0)) && in_data_valid &&
        (auto_cnt_r + CNT_WIDTH'(1) == auto_to_r)) begin
      forced_s = 1'b1;
    end else begin
      forced_s = 1'b0;
    end
`endif
    trig_fire_s = (state_r == ST_WAIT_TRIG) && (edge_s || forced_s);

    we_s = in_data_valid && ((state_r == ST_PREFILL) ||
                             (state_r == ST_WAIT_TRIG) ||
                             (state_r == ST_POST));

    // Two-stage read pipeline: RAM output register feeds the AXIS register
    out_load_s = ~tvalid_r | m_axis_tready;
    a_load_s   = ~a_valid_r | out_load_s;
    rd_en_s    = (state_r == ST_READ) && a_load_s && (issue_cnt_r != total_r);
  end

  capture_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_ram (
    .clk     (clk),
    .we      (we_s),
    .wr_addr (wr_ptr_r),
    .wr_data (in_data),
    .rd_en   (rd_en_s),
    .rd_addr (rd_ptr_r),
    .rd_data (rd_data_s)
  );

  // Capture state machine with registered stream and status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      wr_ptr_r    <= AW'(0);
      rd_ptr_r    <= AW'(0);
      trig_ptr_r  <= AW'(0);
      pre_r       <= AW'(0);
      pre_cnt_r   <= AW'(0);
      post_r      <= SW'(0);
      post_cnt_r  <= SW'(0);
      total_r     <= SW'(0);
      issue_cnt_r <= SW'(0);
      trig_prev_r <= 1'b0;
      a_valid_r   <= 1'b0;
      a_last_r    <= 1'b0;
      tdata_r     <= DATA_WIDTH'(0);
      tvalid_r    <= 1'b0;
      tlast_r     <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
`ifdef AUTO_TRIGGER_EN
      auto_to_r   <= CNT_WIDTH'(0);
      auto_cnt_r  <= CNT_WIDTH'(0);
      auto_trig_r <= 1'b0;
`endif
    end else begin
      trig_prev_r <= trigger;
      done_r      <= 1'b0;
      if (we_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end

      case (state_r)
        ST_IDLE: begin
          if (arm) begin
            pre_r       <= pre_count;
            post_r      <= post_clamp_s;
            total_r     <= total_s;
            pre_cnt_r   <= AW'(0);
            post_cnt_r  <= SW'(0);
            issue_cnt_r <= SW'(0);
            busy_r      <= 1'b1;
            state_r     <= ST_PREFILL;
`ifdef AUTO_TRIGGER_EN
            auto_to_r   <= auto_timeout;
            auto_cnt_r  <= CNT_WIDTH'(0);
            auto_trig_r <= 1'b0;
`endif
          end
        end

        ST_PREFILL: begin
          if (pre_r == AW'(0)) begin
            state_r <= ST_WAIT_TRIG;
          end else if (in_data_valid) begin
            pre_cnt_r <= pre_cnt_r + AW'(1);
            if (pre_cnt_r + AW'(1) == pre_r) begin
              state_r <= ST_WAIT_TRIG;
            end
          end
        end

        ST_WAIT_TRIG: begin
          if (trig_fire_s) begin
            trig_ptr_r <= wr_ptr_r;
`ifdef AUTO_TRIGGER_EN
            auto_trig_r <= forced_s & ~edge_s;
`endif
            // A single-sample post window can close on the trigger cycle itself
            if (in_data_valid && (post_r == SW'(1))) begin
              rd_ptr_r <= wr_ptr_r - pre_r;
              state_r  <= ST_READ;
            end else begin
              post_cnt_r <= in_data_valid ? SW'(1) : SW'(0);
              state_r    <= ST_POST;
            end
          end else begin
`ifdef AUTO_TRIGGER_EN
            if (in_data_valid) begin
              auto_cnt_r <= auto_cnt_r + CNT_WIDTH'(1);
            end
`endif
          end
        end

        ST_POST: begin
          if (in_data_valid) begin
            post_cnt_r <= post_cnt_r + SW'(1);
            if (post_cnt_r + SW'(1) == post_r) begin
              rd_ptr_r <= trig_ptr_r - pre_r;
              state_r  <= ST_READ;
            end
          end
        end

        ST_READ: begin
          if (rd_en_s) begin
            rd_ptr_r    <= rd_ptr_r + AW'(1);
            issue_cnt_r <= issue_cnt_r + SW'(1);
            a_valid_r   <= 1'b1;
            a_last_r    <= (issue_cnt_r + SW'(1) == total_r);
          end else if (a_load_s) begin
            a_valid_r <= 1'b0;
            a_last_r  <= 1'b0;
          end
          if (out_load_s) begin
            tvalid_r <= a_valid_r;
            tlast_r  <= a_valid_r & a_last_r;
            if (a_valid_r) begin
              tdata_r <= rd_data_s;
            end
          end
          if (tvalid_r && m_axis_tready && tlast_r) begin
            tvalid_r  <= 1'b0;
            tlast_r   <= 1'b0;
            a_valid_r <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b1;
            state_r   <= ST_IDLE;
          end
        end

        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign m_axis_tdata  = tdata_r;
  assign m_axis_tvalid = tvalid_r;
  assign m_axis_tlast  = tlast_r;
  assign busy          = busy_r;
  assign done          = done_r;
`ifdef AUTO_TRIGGER_EN
  assign auto_triggered = auto_trig_r;
`endif

endmodule

// File: tb/tb_axis_trigger_capture.sv
// Directed bench for axis_trigger_capture at DEPTH=16; the auto-trigger
// scenario runs only when AUTO_TRIGGER_EN is defined.
module tb_axis_trigger_capture;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_data_valid = 1'b0;
  logic [15:0] in_data = 16'd0;
  logic        trigger = 1'b0;
  logic        arm = 1'b0;
  logic [3:0]  pre_count = 4'd0;
  logic [15:0] post_count = 16'd0;
  logic [15:0] m_axis_tdata;
  logic        m_axis_tvalid, m_axis_tlast;
  logic        m_axis_tready = 1'b0;
  logic        busy, done;
`ifdef AUTO_TRIGGER_EN
  logic [15:0] auto_timeout = 16'd0;
  logic        auto_triggered;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  axis_trigger_capture #(
    .DATA_WIDTH (16),
    .DEPTH      (16),
    .CNT_WIDTH  (16)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .in_data_valid  (in_data_valid),
    .in_data        (in_data),
    .trigger        (trigger),
    .arm            (arm),
    .pre_count      (pre_count),
    .post_count     (post_count),
`ifdef AUTO_TRIGGER_EN
    .auto_timeout   (auto_timeout),
    .auto_triggered (auto_triggered),
`endif
    .m_axis_tdata   (m_axis_tdata),
    .m_axis_tvalid  (m_axis_tvalid),
    .m_axis_tlast   (m_axis_tlast),
    .m_axis_tready  (m_axis_tready),
    .busy           (busy),
    .done           (done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_arm(input int pre, input int post);
    pre_count  = 4'(pre);
    post_count = 16'(post);
    arm = 1'b1;
    @(posedge clk); #1;
    arm = 1'b0;
  endtask

  task automatic send(input int v, input logic trg);
    in_data_valid = 1'b1;
    in_data       = 16'(v);
    trigger       = trg;
    @(posedge clk); #1;
    in_data_valid = 1'b0;
  endtask

  // Accept 'stop' beats of an n-beat capture whose values are first, first+1, ...
  task automatic read_beats(input int first, input int n, input bit toggle, input int stop);
    int got = 0;
    int cyc = 0;
    bit stalled = 1'b0;
    logic [15:0] held_d = 16'd0;
    logic        held_l = 1'b0;
    while (got < stop && cyc < 400) begin
      m_axis_tready = toggle ? (cyc % 2 == 0) : 1'b1;
      if (m_axis_tvalid) begin
        if (stalled) begin
          chk("hold_data", 32'(m_axis_tdata), 32'(held_d));
          chk("hold_last", 32'(m_axis_tlast), 32'(held_l));
        end
        if (m_axis_tready) begin
          chk("beat_data", 32'(m_axis_tdata), 32'(first + got));
          chk("beat_last", 32'(m_axis_tlast), 32'(got == n - 1));
          got++;
          stalled = 1'b0;
        end else begin
          held_d  = m_axis_tdata;
          held_l  = m_axis_tlast;
          stalled = 1'b1;
        end
      end else if (!toggle && got > 0) begin
        chk("no_bubble", 32'(m_axis_tvalid), 32'd1);
      end
      @(posedge clk); #1;
      cyc++;
    end
    m_axis_tready = 1'b0;
    if (got < stop) chk("beat_timeout", 32'(got), 32'(stop));
  endtask

  task automatic check_done();
    chk("tvalid_after", 32'(m_axis_tvalid), 32'd0);
    chk("done_pulse", 32'(done), 32'd1);
    chk("busy_after", 32'(busy), 32'd0);
    @(posedge clk); #1;
    chk("done_low", 32'(done), 32'd0);
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
    chk("rst_tlast", 32'(m_axis_tlast), 32'd0);
    chk("rst_tdata", 32'(m_axis_tdata), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Basic capture: pre=4, post=6, edge with sample 20 -> 16..25
    do_arm(4, 6);
    chk("busy_armed", 32'(busy), 32'd1);
    for (int k = 0; k < 26; k++) send(k, (k >= 20));
    trigger = 1'b0;
    read_beats(16, 10, 1'b0, 10);
    check_done();
`ifdef AUTO_TRIGGER_EN
    chk("auto_flag_clear", 32'(auto_triggered), 32'd0);
`endif

    // Same capture with tready toggling every cycle
    do_arm(4, 6);
    for (int k = 0; k < 26; k++) send(k, (k >= 20));
    trigger = 1'b0;
    read_beats(16, 10, 1'b1, 10);
    check_done();

    // Trigger already high on WAIT_TRIG entry; fresh edge at sample 30
    trigger = 1'b1;
    @(posedge clk); #1;
    do_arm(4, 6);
    for (int k = 22; k < 27; k++) send(k, 1'b1);
    for (int k = 27; k < 30; k++) send(k, 1'b0);
    for (int k = 30; k < 36; k++) send(k, 1'b1);
    trigger = 1'b0;
    read_beats(26, 10, 1'b0, 10);
    check_done();

    // Largest pre (15) forces post 10 -> 1: full 16-entry window 105..120
    do_arm(15, 10);
    for (int k = 100; k < 120; k++) send(k, 1'b0);
    send(120, 1'b1);
    trigger = 1'b0;
    read_beats(105, 16, 1'b0, 16);
    check_done();

    // post_count 0 behaves as 1
    do_arm(2, 0);
    for (int k = 200; k < 204; k++) send(k, 1'b0);
    send(204, 1'b1);
    trigger = 1'b0;
    read_beats(202, 3, 1'b0, 3);
    check_done();

    // Reset mid-READ after 3 beats, then a fresh capture
    do_arm(4, 6);
    for (int k = 40; k < 66; k++) send(k, (k >= 60));
    trigger = 1'b0;
    read_beats(56, 10, 1'b0, 3);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_tvalid", 32'(m_axis_tvalid), 32'd0);
    chk("midrst_tlast", 32'(m_axis_tlast), 32'd0);
    chk("midrst_tdata", 32'(m_axis_tdata), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    do_arm(4, 6);
    for (int k = 0; k < 26; k++) send(k, (k >= 20));
    trigger = 1'b0;
    read_beats(16, 10, 1'b0, 10);
    check_done();

`ifdef AUTO_TRIGGER_EN
    // Forced trigger on the 8th WAIT_TRIG sample (311) -> 307..316
    auto_timeout = 16'd8;
    do_arm(4, 6);
    auto_timeout = 16'd0;
    for (int k = 300; k < 317; k++) send(k, 1'b0);
    read_beats(307, 10, 1'b0, 10);
    check_done();
    chk("auto_flag_set", 32'(auto_triggered), 32'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
